// File: rtl/udp_rx_cmd_filter_if.sv
// ----------------------------------------------------------------------------
// udp_rx_cmd_filter_if
// Purpose : Bundles the UDP header handshake, the incoming UDP payload stream
//           and the outgoing command stream used by udp_rx_cmd_filter.
// Signals : i_rx_udp_hdr_valid / o_rx_udp_hdr_ready       header handshake
//           i_rx_udp_ip_dest_ip[31:0], i_rx_udp_dest_port  header fields
//           i_rx_udp_payload_axis_tdata/tvalid/tlast       payload in
//           o_rx_udp_payload_axis_tready                   payload accept
//           o_cmd_axis_tdata/tvalid/tlast                  filtered payload out
//           i_cmd_axis_tready                              parser accept
// Modports: slave  - filter side (i_* inputs, o_* outputs)
//           master - UDP stack / parser side (drives i_*, observes o_*)
// ----------------------------------------------------------------------------
interface udp_rx_cmd_filter_if;
   logic        i_rx_udp_hdr_valid;
   logic        o_rx_udp_hdr_ready;
   logic [31:0] i_rx_udp_ip_dest_ip;
   logic [15:0] i_rx_udp_dest_port;
   logic [7:0]  i_rx_udp_payload_axis_tdata;
   logic        i_rx_udp_payload_axis_tvalid;
   logic        i_rx_udp_payload_axis_tlast;
   logic        o_rx_udp_payload_axis_tready;
   logic [7:0]  o_cmd_axis_tdata;
   logic        o_cmd_axis_tvalid;
   logic        o_cmd_axis_tlast;
   logic        i_cmd_axis_tready;

   modport slave (
      input  i_rx_udp_hdr_valid,
      output o_rx_udp_hdr_ready,
      input  i_rx_udp_ip_dest_ip,
      input  i_rx_udp_dest_port,
      input  i_rx_udp_payload_axis_tdata,
      input  i_rx_udp_payload_axis_tvalid,
      input  i_rx_udp_payload_axis_tlast,
      output o_rx_udp_payload_axis_tready,
      output o_cmd_axis_tdata,
      output o_cmd_axis_tvalid,
      output o_cmd_axis_tlast,
      input  i_cmd_axis_tready
   );

   modport master (
      output i_rx_udp_hdr_valid,
      input  o_rx_udp_hdr_ready,
      output i_rx_udp_ip_dest_ip,
      output i_rx_udp_dest_port,
      output i_rx_udp_payload_axis_tdata,
      output i_rx_udp_payload_axis_tvalid,
      output i_rx_udp_payload_axis_tlast,
      input  o_rx_udp_payload_axis_tready,
      input  o_cmd_axis_tdata,
      input  o_cmd_axis_tvalid,
      input  o_cmd_axis_tlast,
      output i_cmd_axis_tready
   );
endinterface

// File: rtl/udp_rx_cmd_filter.sv
// ----------------------------------------------------------------------------
// udp_rx_cmd_filter
// Purpose : Passes the payload of UDP packets addressed to IP_ADRESS:PORT_NUMBER
//           to a command parser, truncated to MAX_LEN bytes (last byte of a
//           truncated packet is flagged tlast). Other packets are consumed and
//           discarded. Payload goes through a 2-entry skid buffer so the input
//           ready is registered while sustaining one byte per cycle.
// Ports   : i_clk            clock, rising edge
//           i_rst            asynchronous active-high reset
//           io_bus           udp_rx_cmd_filter_if.slave (header, payload, cmd)
//           o_ip_adr[31:0]   destination IP latched at the last header
//           o_port_nbr[15:0] destination port latched at the last header
//           o_pkt_accept_cnt / o_pkt_drop_cnt [15:0]  (UDP_RX_CMD_FILTER_STATS_EN)
// Options : `define UDP_RX_CMD_FILTER_STATS_EN adds accepted/dropped packet
//           counters; without it those ports and their logic are absent.
// ----------------------------------------------------------------------------
module udp_rx_cmd_filter #(
   parameter logic [31:0] IP_ADRESS   = {8'd192, 8'd168, 8'd1, 8'd128},
   parameter logic [15:0] PORT_NUMBER = 16'd1234,
   parameter int unsigned MAX_LEN     = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   udp_rx_cmd_filter_if.slave  io_bus,
   output logic [31:0]         o_ip_adr,
   output logic [15:0]         o_port_nbr
`ifdef UDP_RX_CMD_FILTER_STATS_EN
   ,
   output logic [15:0]         o_pkt_accept_cnt,
   output logic [15:0]         o_pkt_drop_cnt
`endif
);

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DATA_W  = 8;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [31:0]       r_ip_adr;
   logic [15:0]       r_port_nbr;
   logic              r_hdr_ready;
   logic              r_pay_ready;
   // skid buffer: entry 0 is the output register, entry 1 the overflow slot
   logic              r_v0, r_l0, r_v1, r_l1;
   logic [DATA_W-1:0] r_d0, r_d1;

   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_hdr_xfer, w_pay_xfer, w_match, w_push, w_pop, w_fwd_last;
   logic              w_v0_nxt, w_l0_nxt, w_v1_nxt, w_l1_nxt;
   logic [DATA_W-1:0] w_d0_nxt, w_d1_nxt;
   logic              w_hdr_ready_nxt, w_pay_ready_nxt;

   assign w_hdr_xfer = io_bus.i_rx_udp_hdr_valid && r_hdr_ready;
   assign w_pay_xfer = io_bus.i_rx_udp_payload_axis_tvalid && r_pay_ready;
   assign w_match    = (io_bus.i_rx_udp_ip_dest_ip == IP_ADRESS) &&
                       (io_bus.i_rx_udp_dest_port == PORT_NUMBER);
   assign w_push     = w_pay_xfer && (r_state == S_PASS);
   assign w_pop      = r_v0 && io_bus.i_cmd_axis_tready;
   // a forwarded byte closes the packet on its own tlast or at the length limit
   assign w_fwd_last = io_bus.i_rx_udp_payload_axis_tlast || (r_byte_cnt == LAST_IDX);

   // Next state, byte counter, skid buffer and registered ready values
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_byte_cnt;
      w_v0_nxt    = r_v0;
      w_l0_nxt    = r_l0;
      w_d0_nxt    = r_d0;
      w_v1_nxt    = r_v1;
      w_l1_nxt    = r_l1;
      w_d1_nxt    = r_d1;

      case (r_state)
         S_IDLE: begin
            if (w_hdr_xfer) begin
               w_state_nxt = w_match ? S_PASS : S_DROP;
               w_cnt_nxt   = '0;
            end
         end
         S_PASS: begin
            if (w_pay_xfer) begin
               w_cnt_nxt = r_byte_cnt + CNT_W'(1);
               if (io_bus.i_rx_udp_payload_axis_tlast) begin
                  w_state_nxt = S_IDLE;
               end else if (r_byte_cnt == LAST_IDX) begin
                  w_state_nxt = S_DROP;
               end
            end
         end
         S_DROP: begin
            if (w_pay_xfer && io_bus.i_rx_udp_payload_axis_tlast) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_pop) begin
         if (w_push && r_v1) begin
            w_d0_nxt = r_d1;
            w_l0_nxt = r_l1;
            w_d1_nxt = io_bus.i_rx_udp_payload_axis_tdata;
            w_l1_nxt = w_fwd_last;
         end else if (w_push) begin
            w_d0_nxt = io_bus.i_rx_udp_payload_axis_tdata;
            w_l0_nxt = w_fwd_last;
         end else begin
            w_d0_nxt = r_d1;
            w_l0_nxt = r_l1;
            w_v0_nxt = r_v1;
            w_v1_nxt = 1'b0;
         end
      end else if (w_push) begin
         if (r_v0) begin
            w_d1_nxt = io_bus.i_rx_udp_payload_axis_tdata;
            w_l1_nxt = w_fwd_last;
            w_v1_nxt = 1'b1;
         end else begin
            w_d0_nxt = io_bus.i_rx_udp_payload_axis_tdata;
            w_l0_nxt = w_fwd_last;
            w_v0_nxt = 1'b1;
         end
      end

      // a new header waits until every byte of the previous packet has left
      w_hdr_ready_nxt = (w_state_nxt == S_IDLE) && !w_v0_nxt;
      w_pay_ready_nxt = (w_state_nxt == S_PASS) ? !w_v1_nxt : (w_state_nxt == S_DROP);
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_byte_cnt  <= '0;
         r_ip_adr    <= '0;
         r_port_nbr  <= '0;
         r_hdr_ready <= 1'b1;
         r_pay_ready <= 1'b0;
         r_v0        <= 1'b0;
         r_l0        <= 1'b0;
         r_d0        <= '0;
         r_v1        <= 1'b0;
         r_l1        <= 1'b0;
         r_d1        <= '0;
      end else begin
         r_byte_cnt  <= w_cnt_nxt;
         r_hdr_ready <= w_hdr_ready_nxt;
         r_pay_ready <= w_pay_ready_nxt;
         r_v0        <= w_v0_nxt;
         r_l0        <= w_l0_nxt;
         r_d0        <= w_d0_nxt;
         r_v1        <= w_v1_nxt;
         r_l1        <= w_l1_nxt;
         r_d1        <= w_d1_nxt;
         if (w_hdr_xfer) begin
            r_ip_adr   <= io_bus.i_rx_udp_ip_dest_ip;
            r_port_nbr <= io_bus.i_rx_udp_dest_port;
         end
      end
   end

`ifdef UDP_RX_CMD_FILTER_STATS_EN
   logic [15:0] r_pkt_accept_cnt;
   logic [15:0] r_pkt_drop_cnt;

   // Per-header packet statistics; truncation does not count as a drop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pkt_accept_cnt <= '0;
         r_pkt_drop_cnt   <= '0;
      end else if (w_hdr_xfer) begin
         if (w_match) begin
            r_pkt_accept_cnt <= r_pkt_accept_cnt + 16'd1;
         end else begin
            r_pkt_drop_cnt <= r_pkt_drop_cnt + 16'd1;
         end
      end
   end

   assign o_pkt_accept_cnt = r_pkt_accept_cnt;
   assign o_pkt_drop_cnt   = r_pkt_drop_cnt;
`endif

   assign io_bus.o_rx_udp_hdr_ready           = r_hdr_ready;
   assign io_bus.o_rx_udp_payload_axis_tready = r_pay_ready;
   assign io_bus.o_cmd_axis_tvalid            = r_v0;
   assign io_bus.o_cmd_axis_tdata             = r_d0;
   assign io_bus.o_cmd_axis_tlast             = r_l0;
   assign o_ip_adr                            = r_ip_adr;
   assign o_port_nbr                          = r_port_nbr;

endmodule

// File: tb/tb_udp_rx_cmd_filter.sv
// ----------------------------------------------------------------------------
// tb_udp_rx_cmd_filter
// Purpose : Directed self-checking bench for udp_rx_cmd_filter (default
//           parameters). Inputs change 1 time unit after the rising edge;
//           outputs are sampled on the falling edge or 1 unit after the
//           rising edge. Stats checks compile in with UDP_RX_CMD_FILTER_STATS_EN.
// ----------------------------------------------------------------------------
module tb_udp_rx_cmd_filter;

   localparam logic [31:0] IP_OK  = 32'hC0A8_0180;  // 192.168.1.128
   localparam logic [31:0] IP_BAD = 32'hC0A8_0181;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } ob_t;

   logic        clk;
   logic        rst;
   logic [31:0] ip_adr;
   logic [15:0] port_nbr;
`ifdef UDP_RX_CMD_FILTER_STATS_EN
   logic [15:0] acc_cnt;
   logic [15:0] drop_cnt;
`endif

   int   total;
   int   bad;
   ob_t  q[$];
   logic [7:0] p1 [7];

   udp_rx_cmd_filter_if bus ();

   udp_rx_cmd_filter dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .io_bus           (bus),
      .o_ip_adr         (ip_adr),
      .o_port_nbr       (port_nbr)
`ifdef UDP_RX_CMD_FILTER_STATS_EN
      ,
      .o_pkt_accept_cnt (acc_cnt),
      .o_pkt_drop_cnt   (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every output beat that will transfer at the next rising edge
   always @(negedge clk) begin
      if (bus.o_cmd_axis_tvalid === 1'b1 && bus.i_cmd_axis_tready === 1'b1)
         q.push_back('{d: bus.o_cmd_axis_tdata, l: bus.o_cmd_axis_tlast});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_hdr(input logic [31:0] ip, input logic [15:0] port);
      bit done = 1'b0;
      bus.i_rx_udp_ip_dest_ip = ip;
      bus.i_rx_udp_dest_port  = port;
      bus.i_rx_udp_hdr_valid  = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = bus.o_rx_udp_hdr_ready;
      end
      @(posedge clk); #1;
      bus.i_rx_udp_hdr_valid = 1'b0;
      check("hdr_accepted", 32'(done), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] data, input logic last);
      bit done = 1'b0;
      bus.i_rx_udp_payload_axis_tdata  = data;
      bus.i_rx_udp_payload_axis_tlast  = last;
      bus.i_rx_udp_payload_axis_tvalid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = bus.o_rx_udp_payload_axis_tready;
      end
      @(posedge clk); #1;
      bus.i_rx_udp_payload_axis_tvalid = 1'b0;
      bus.i_rx_udp_payload_axis_tlast  = 1'b0;
      check("byte_accepted", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_tvalid"}, 32'(bus.o_cmd_axis_tvalid), 32'd0);
      check({tag, "_tdata"},  32'(bus.o_cmd_axis_tdata), 32'd0);
      check({tag, "_tlast"},  32'(bus.o_cmd_axis_tlast), 32'd0);
      check({tag, "_pready"}, 32'(bus.o_rx_udp_payload_axis_tready), 32'd0);
      check({tag, "_ip"},     ip_adr, 32'd0);
      check({tag, "_port"},   32'(port_nbr), 32'd0);
   endtask

   initial begin
      int   idx;
      int   nlast;
      int   nerr;
      bit   acc;
      bit   tog;
      bit   hdr_done;

      total = 0;
      bad   = 0;
      p1 = '{8'h3A, 8'h31, 8'h57, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      rst = 1'b1;
      bus.i_rx_udp_hdr_valid           = 1'b0;
      bus.i_rx_udp_ip_dest_ip          = '0;
      bus.i_rx_udp_dest_port           = '0;
      bus.i_rx_udp_payload_axis_tdata  = '0;
      bus.i_rx_udp_payload_axis_tvalid = 1'b0;
      bus.i_rx_udp_payload_axis_tlast  = 1'b0;
      bus.i_cmd_axis_tready            = 1'b1;

      // Reset state
      idle(3);
      check_zero_outputs("rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("hdr_ready_after_rst", 32'(bus.o_rx_udp_hdr_ready), 32'd1);

      // Matching packet ":1W" DE AD BE EF, one-cycle latency per byte
      q.delete();
      send_hdr(IP_OK, 16'd1234);
      check("t1_port", 32'(port_nbr), 32'd1234);
      check("t1_ip", ip_adr, IP_OK);
      for (int k = 0; k < 7; k++) begin
         send_byte(p1[k], k == 6);
         check("t1_lat_valid", 32'(bus.o_cmd_axis_tvalid), 32'd1);
         check("t1_lat_data", 32'(bus.o_cmd_axis_tdata), 32'(p1[k]));
         check("t1_lat_last", 32'(bus.o_cmd_axis_tlast), 32'(k == 6));
      end
      idle(3);
      check("t1_count", 32'(q.size()), 32'd7);
      nerr = 0;
      for (int k = 0; k < q.size() && k < 7; k++)
         if (q[k].d !== p1[k] || q[k].l !== (k == 6)) nerr++;
      check("t1_sequence_errs", 32'(nerr), 32'd0);
      check("t1_idle_ready", 32'(bus.o_rx_udp_hdr_ready), 32'd1);

      // Non-matching port: 5 bytes consumed, nothing forwarded
      q.delete();
      send_hdr(IP_OK, 16'd1235);
      check("t2_port", 32'(port_nbr), 32'd1235);
      for (int k = 0; k < 5; k++) send_byte(8'(8'h10 + k), k == 4);
      check("t2_back_idle", 32'(bus.o_rx_udp_hdr_ready), 32'd1);
      idle(2);
      check("t2_count", 32'(q.size()), 32'd0);

      // 70-byte packet truncated to 64 bytes
      q.delete();
      send_hdr(IP_OK, 16'd1234);
      for (int k = 0; k < 70; k++) send_byte(8'(k), k == 69);
      idle(3);
      check("t3_count", 32'(q.size()), 32'd64);
      nerr  = 0;
      nlast = 0;
      for (int k = 0; k < q.size(); k++) begin
         if (q[k].d !== 8'(k)) nerr++;
         if (q[k].l === 1'b1) nlast++;
      end
      check("t3_data_errs", 32'(nerr), 32'd0);
      check("t3_one_tlast", 32'(nlast), 32'd1);
      if (q.size() == 64) check("t3_last_on_64", 32'(q[63].l), 32'd1);
      check("t3_idle_ready", 32'(bus.o_rx_udp_hdr_ready), 32'd1);

      // 4-byte packet with output ready toggling; next header stalled
      q.delete();
      send_hdr(IP_OK, 16'd1234);
      idx = 0;
      tog = 1'b1;
      for (int c = 0; c < 60 && idx < 4; c++) begin
         bus.i_cmd_axis_tready            = tog;
         tog                              = ~tog;
         bus.i_rx_udp_payload_axis_tvalid = 1'b1;
         bus.i_rx_udp_payload_axis_tdata  = 8'(8'hA0 + idx);
         bus.i_rx_udp_payload_axis_tlast  = (idx == 3);
         @(negedge clk);
         acc = bus.o_rx_udp_payload_axis_tready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      bus.i_rx_udp_payload_axis_tvalid = 1'b0;
      bus.i_rx_udp_payload_axis_tlast  = 1'b0;
      check("t4_all_in", 32'(idx), 32'd4);
      bus.i_rx_udp_ip_dest_ip = IP_OK;
      bus.i_rx_udp_dest_port  = 16'd1234;
      bus.i_rx_udp_hdr_valid  = 1'b1;
      hdr_done = 1'b0;
      for (int c = 0; c < 60 && !hdr_done; c++) begin
         bus.i_cmd_axis_tready = tog;
         tog                   = ~tog;
         @(negedge clk);
         hdr_done = bus.o_rx_udp_hdr_ready;
         @(posedge clk); #1;
      end
      bus.i_rx_udp_hdr_valid = 1'b0;
      bus.i_cmd_axis_tready  = 1'b1;
      check("t4_hdr2_accepted", 32'(hdr_done), 32'd1);
      check("t4_drained_before_hdr2", 32'(q.size()), 32'd4);
      nerr = 0;
      for (int k = 0; k < q.size() && k < 4; k++)
         if (q[k].d !== 8'(8'hA0 + k) || q[k].l !== (k == 3)) nerr++;
      check("t4_sequence_errs", 32'(nerr), 32'd0);
      send_byte(8'h55, 1'b1);
      idle(2);
      check("t4_count_after", 32'(q.size()), 32'd5);
      if (q.size() == 5) check("t4_hdr2_byte", 32'(q[4].d), 32'h55);

      // Reset after 2 of 6 payload bytes
      send_hdr(IP_OK, 16'd1234);
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      rst = 1'b1;
      #1;
      check_zero_outputs("t5_rst");
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 2; k < 6; k++) begin
         bus.i_rx_udp_payload_axis_tvalid = 1'b1;
         bus.i_rx_udp_payload_axis_tdata  = 8'(8'h61 + k);
         bus.i_rx_udp_payload_axis_tlast  = (k == 5);
         @(negedge clk);
         check("t5_no_pready", 32'(bus.o_rx_udp_payload_axis_tready), 32'd0);
         @(posedge clk); #1;
      end
      bus.i_rx_udp_payload_axis_tvalid = 1'b0;
      bus.i_rx_udp_payload_axis_tlast  = 1'b0;
      idle(2);
      check("t5_nothing_out", 32'(q.size()), 32'd0);

      // 3 matching + 2 non-matching one-byte packets
      q.delete();
      for (int k = 0; k < 5; k++) begin
         send_hdr((k == 1 || k == 3) ? IP_BAD : IP_OK, 16'd1234);
         send_byte(8'(8'hC0 + k), 1'b1);
      end
      idle(3);
      check("t6_count", 32'(q.size()), 32'd3);
      if (q.size() == 3) begin
         check("t6_b0", 32'(q[0].d), 32'hC0);
         check("t6_b1", 32'(q[1].d), 32'hC2);
         check("t6_b2", 32'(q[2].d), 32'hC4);
      end
`ifdef UDP_RX_CMD_FILTER_STATS_EN
      check("t6_accept_cnt", 32'(acc_cnt), 32'd3);
      check("t6_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
